// File: rtl/if_stage_pkg.sv
// if_stage_pkg: fetch-stage defaults, state encoding and the IF/ID bundle shared with decode
package if_stage_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} fetch_state_t;
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;
endpackage

// File: rtl/if_stage_if_id_register.sv
// if_id_register: IF/ID pipeline register with write enable and flush-to-bubble
module if_id_register
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        flush,
    input  logic        fill,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output if_id_t      q
);
    if_id_t d;
    always_comb d = (fill && !flush) ? {instr, pc, 1'b1} : {NOP_INSTR, pc, 1'b0};
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= {NOP_INSTR, RESET_PC, 1'b0};
        else if (flush || we) q <= d;
endmodule

// File: rtl/if_stage.sv
// if_stage: PC register, next-PC selection, BOOT/RUN control and fetch counters feeding IF/ID
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter int          CNT_W     = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             PC_WriteEnable,
    input  logic             IFIDWriteEnable,
    input  logic             IFIDFlush,
    input  logic             Branch,
    input  logic [31:0]      BranchDest,
    input  logic             Jump,
    input  logic [31:0]      JumpDest,
    input  logic             IMemReady,
    input  logic [31:0]      IMemRdData,
    output logic [31:0]      IMemAddr,
    output logic             IMemReq,
    output logic [31:0]      Instruction_Out,
    output logic [31:0]      PC_Out,
    output logic             Valid_Out,
    output logic [CNT_W-1:0] FetchCount,
    output logic [CNT_W-1:0] StallCount
);
    fetch_state_t state;
    logic [31:0]  pc, pc_next, target;
    logic         run, fill, redirect;
    if_id_t       if_id;
    assign run = (state == RUN);
    assign fill = run && IMemReady;
    assign redirect = Jump || Branch;
    always_comb begin
        target = Jump ? JumpDest : BranchDest;
        pc_next = (!(run && PC_WriteEnable) || (!redirect && !IMemReady)) ? pc :
                  redirect ? {target[31:2], 2'b00} : pc + 32'd4;
    end
    always_ff @(posedge Clock or posedge Reset)
        if (Reset) begin
            state <= BOOT;
            pc <= RESET_PC;
            FetchCount <= '0;
            StallCount <= '0;
        end else begin
            state <= RUN;
            pc <= pc_next;
            FetchCount <= FetchCount + CNT_W'(fill && IFIDWriteEnable && !IFIDFlush);
            StallCount <= StallCount + CNT_W'(run && !IMemReady);
        end
    if_id_register #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk(Clock),
        .rst(Reset),
        .we(IFIDWriteEnable),
        .flush(IFIDFlush),
        .fill(fill),
        .instr(IMemRdData),
        .pc(pc),
        .q(if_id)
    );
    assign IMemAddr = pc;
    assign IMemReq = run;
    assign Instruction_Out = if_id.instruction;
    assign PC_Out = if_id.pc;
    assign Valid_Out = if_id.valid;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized scoreboard bench for if_stage against a behavioural fetch model
module tb_if_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int CW = 8;
    logic          Clock = 1'b0, Reset = 1'b1;
    logic          PC_WriteEnable = 1'b1, IFIDWriteEnable = 1'b1, IFIDFlush = 1'b0;
    logic          Branch = 1'b0, Jump = 1'b0, IMemReady = 1'b1;
    logic [31:0]   BranchDest = '0, JumpDest = '0, IMemRdData, IMemAddr, Instruction_Out, PC_Out;
    logic          IMemReq, Valid_Out;
    logic [CW-1:0] FetchCount, StallCount;
    if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP), .CNT_W(CW)) dut (
        .Clock(Clock), .Reset(Reset), .PC_WriteEnable(PC_WriteEnable),
        .IFIDWriteEnable(IFIDWriteEnable), .IFIDFlush(IFIDFlush), .Branch(Branch),
        .BranchDest(BranchDest), .Jump(Jump), .JumpDest(JumpDest), .IMemReady(IMemReady),
        .IMemRdData(IMemRdData), .IMemAddr(IMemAddr), .IMemReq(IMemReq),
        .Instruction_Out(Instruction_Out), .PC_Out(PC_Out), .Valid_Out(Valid_Out),
        .FetchCount(FetchCount), .StallCount(StallCount)
    );
    always #5 Clock = ~Clock;
    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h2000_0000 + a;
    endfunction
    assign IMemRdData = mem(IMemAddr);
    typedef struct {
        logic [31:0]   addr, instr, pco;
        logic          req, valid;
        logic [CW-1:0] fc, sc;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    logic [31:0]   m_pc, m_instr, m_pco;
    logic          m_run, m_valid;
    logic [CW-1:0] m_fc, m_sc;
    int checks = 0, failures = 0;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", n, a, x, $time);
        end
    endtask
    task automatic model_reset();
        m_pc = RST_PC; m_run = 1'b0; m_instr = NOP; m_pco = RST_PC;
        m_valid = 1'b0; m_fc = '0; m_sc = '0;
    endtask
    always @(posedge Clock) begin
        #1;
        if (!Reset && sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_addr", IMemAddr, e.addr);
            chk("sb_req", {31'b0, IMemReq}, {31'b0, e.req});
            chk("sb_instr", Instruction_Out, e.instr);
            chk("sb_pc_out", PC_Out, e.pco);
            chk("sb_valid", {31'b0, Valid_Out}, {31'b0, e.valid});
            chk("sb_fetch_cnt", {24'b0, FetchCount}, {24'b0, e.fc});
            chk("sb_stall_cnt", {24'b0, StallCount}, {24'b0, e.sc});
        end
    end
    task automatic step(input logic pcwe, input logic ifwe, input logic fl, input logic br,
                        input logic [31:0] bd, input logic j, input logic [31:0] jd, input logic rdy);
        logic [31:0] npc;
        @(negedge Clock);
        PC_WriteEnable = pcwe; IFIDWriteEnable = ifwe; IFIDFlush = fl;
        Branch = br; BranchDest = bd; Jump = j; JumpDest = jd; IMemReady = rdy;
        npc = m_pc;
        if (fl) begin
            m_instr = NOP; m_pco = m_pc; m_valid = 1'b0;
        end else if (ifwe) begin
            if (m_run && rdy) begin
                m_instr = mem(m_pc); m_pco = m_pc; m_valid = 1'b1; m_fc = m_fc + 1'b1;
            end else begin
                m_instr = NOP; m_pco = m_pc; m_valid = 1'b0;
            end
        end
        if (m_run) begin
            if (!rdy) m_sc = m_sc + 1'b1;
            if (pcwe) npc = j ? (jd & ~32'd3) : br ? (bd & ~32'd3) : rdy ? m_pc + 32'd4 : m_pc;
        end
        m_pc = npc;
        m_run = 1'b1;
        sb.push_back('{m_pc, m_instr, m_pco, m_run, m_valid, m_fc, m_sc});
    endtask
    task automatic go(input logic pcwe, input logic ifwe, input logic fl, input logic br,
                      input logic [31:0] bd, input logic j, input logic [31:0] jd, input logic rdy);
        step(pcwe, ifwe, fl, br, bd, j, jd, rdy);
        @(posedge Clock);
        #2;
    endtask
    task automatic nominal();
        go(1, 1, 0, 0, 0, 0, 0, 1);
    endtask
    task automatic do_reset();
        @(negedge Clock);
        #2 Reset = 1'b1;
        #1;
        chk("rst_addr", IMemAddr, RST_PC);
        chk("rst_req", {31'b0, IMemReq}, 32'd0);
        chk("rst_instr", Instruction_Out, NOP);
        chk("rst_pc_out", PC_Out, RST_PC);
        chk("rst_valid", {31'b0, Valid_Out}, 32'd0);
        chk("rst_counts", {16'b0, FetchCount, StallCount}, 32'd0);
        sb.delete();
        model_reset();
        PC_WriteEnable = 1'b1; IFIDWriteEnable = 1'b1; IFIDFlush = 1'b0;
        Branch = 1'b0; Jump = 1'b0; IMemReady = 1'b1;
        @(posedge Clock);
        @(posedge Clock);
        #1 Reset = 1'b0;
    endtask
    initial begin
        logic [CW-1:0] fc0;
        logic j, br, fl;
        model_reset();
        do_reset();
        nominal();
        chk("boot_addr", IMemAddr, 32'h0);
        chk("boot_valid", {31'b0, Valid_Out}, 32'd0);
        nominal();
        chk("first_addr", IMemAddr, 32'h4);
        chk("first_instr", Instruction_Out, 32'h2000_0000);
        nominal();
        chk("second_addr", IMemAddr, 32'h8);
        chk("second_instr", Instruction_Out, 32'h2000_0004);
        chk("second_fc", {24'b0, FetchCount}, 32'd2);
        go(1, 1, 1, 0, 0, 1, 32'h0000_0103, 1);
        chk("jump_addr", IMemAddr, 32'h100);
        chk("jump_bubble", {31'b0, Valid_Out}, 32'd0);
        nominal();
        chk("jump_target_instr", Instruction_Out, 32'h2000_0100);
        chk("jump_target_valid", {31'b0, Valid_Out}, 32'd1);
        go(1, 1, 1, 1, 32'h80, 1, 32'h40, 1);
        chk("jump_over_branch", IMemAddr, 32'h40);
        go(1, 1, 1, 0, 0, 1, 32'hC, 1);
        nominal();
        chk("pre_stall_addr", IMemAddr, 32'h10);
        fc0 = FetchCount;
        for (int i = 0; i < 3; i++) go(0, 0, 0, 0, 0, 0, 0, 1);
        chk("stall_addr", IMemAddr, 32'h10);
        chk("stall_instr", Instruction_Out, 32'h2000_000C);
        chk("stall_fc", {24'b0, FetchCount}, {24'b0, fc0});
        nominal();
        chk("stall_release", IMemAddr, 32'h14);
        go(1, 1, 1, 0, 0, 1, 32'h20, 1);
        go(1, 1, 0, 0, 0, 0, 0, 0);
        go(1, 1, 0, 0, 0, 0, 0, 0);
        chk("notready_addr", IMemAddr, 32'h20);
        chk("notready_valid", {31'b0, Valid_Out}, 32'd0);
        chk("notready_sc", {24'b0, StallCount}, 32'd2);
        go(1, 1, 1, 1, 32'h60, 0, 0, 0);
        chk("branch_in_stall", IMemAddr, 32'h60);
        go(1, 1, 1, 0, 0, 1, 32'hFFFF_FFFC, 1);
        nominal();
        chk("wrap_addr", IMemAddr, 32'h0);
        chk("wrap_instr", Instruction_Out, 32'h1FFF_FFFC);
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            j = ($urandom_range(0, 19) == 0);
            br = ($urandom_range(0, 9) == 0);
            fl = j || br || ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, fl, br, $urandom(),
                 j, $urandom(), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) do_reset();
        end
        nominal();
        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
